edge_interval_timer: RTL

- Measures the clock-cycle interval between a start strobe and a stop strobe in the password timing-attack path.
- Start comes from the host UART receive-valid pulse; stop comes from the target-response pattern detector.
- Produces a latched WIDTH-bit interval and a one-cycle valid pulse, which feed the 4-byte UART word transmitter.
- Keeps running min/max/sample-count statistics so the host can read attempt-to-attempt timing spread.

---
 rtl/edge_interval_timer.sv | 118 +++++++++++
 1 files changed

// File: rtl/edge_interval_timer.sv
// rtl/edge_interval_timer.sv - start/stop strobe interval timer with min/max/sample statistics
module edge_interval_timer #(
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 50_000_000,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear_stats,
    output logic             busy,
    output logic [WIDTH-1:0] interval,
    output logic             interval_valid,
    output logic             timeout,
    output logic [WIDTH-1:0] min_interval,
    output logic [WIDTH-1:0] max_interval,
    output logic [CNT_W-1:0] samples
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_RUN    = 1'b1;
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] r_interval;
    logic             r_valid;
    logic             r_timeout;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [CNT_W-1:0] r_samples;

    logic             w_run;
    logic             w_done;
    logic             w_expire;
    logic [WIDTH-1:0] w_min_base;
    logic [WIDTH-1:0] w_max_base;
    logic [CNT_W-1:0] w_samp_base;
    logic [WIDTH-1:0] w_min_next;
    logic [WIDTH-1:0] w_max_next;
    logic [CNT_W-1:0] w_samp_next;

    // Start always wins over stop and timeout; stop wins over timeout.
    assign w_run    = (r_state == ST_RUN);
    assign w_done   = w_run && stop && !start;
    assign w_expire = w_run && !start && !stop && (r_counter == TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_counter  <= '0;
            r_interval <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_valid   <= w_done;
            r_timeout <= w_expire;
            if (w_done) begin
                r_interval <= r_counter;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_counter <= WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        r_counter <= WIDTH'(1);
                    end else if (w_done || w_expire) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_counter <= r_counter + WIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A clear coinciding with a completion folds into the cleared baseline, so the value becomes the first sample.
    always_comb begin
        w_min_base  = clear_stats ? '1 : r_min;
        w_max_base  = clear_stats ? '0 : r_max;
        w_samp_base = clear_stats ? '0 : r_samples;
        w_min_next  = w_min_base;
        w_max_next  = w_max_base;
        w_samp_next = w_samp_base;
        if (w_done) begin
            if (r_counter < w_min_base) w_min_next = r_counter;
            if (r_counter > w_max_base) w_max_next = r_counter;
            if (w_samp_base != '1)      w_samp_next = w_samp_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min     <= '1;
            r_max     <= '0;
            r_samples <= '0;
        end else if (clear_stats || w_done) begin
            r_min     <= w_min_next;
            r_max     <= w_max_next;
            r_samples <= w_samp_next;
        end
    end

    assign busy           = w_run;
    assign interval       = r_interval;
    assign interval_valid = r_valid;
    assign timeout        = r_timeout;
    assign min_interval   = r_min;
    assign max_interval   = r_max;
    assign samples        = r_samples;

endmodule
